// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared config struct, limits and clamp helpers for clk_div_multi (CLK_DIV_FRAC_EN adds the frac field)
package clk_div_pkg;

    // Internal field widths; top-level DIV_W/FRAC_W must not exceed these.
    localparam int CFG_DIV_W  = 16;
    localparam int CFG_FRAC_W = 8;

    localparam logic [CFG_DIV_W-1:0] DIV_MIN = CFG_DIV_W'(2);

    typedef struct packed {
        logic                  en;
        logic [CFG_DIV_W-1:0]  div;
        logic [CFG_DIV_W-1:0]  phase;
`ifdef CLK_DIV_FRAC_EN
        logic [CFG_FRAC_W-1:0] frac;
`endif
    } ch_cfg_t;

    function automatic logic [CFG_DIV_W-1:0] clamp_div(input logic [CFG_DIV_W-1:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    // Phase is checked against the already-clamped divide it will run with.
    function automatic logic [CFG_DIV_W-1:0] clamp_phase(input logic [CFG_DIV_W-1:0] p,
                                                         input logic [CFG_DIV_W-1:0] d);
        return (p >= d) ? '0 : p;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - one divider channel: counter, boundary apply, registered outclk/strobe (CLK_DIV_FRAC_EN adds accumulator)
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int DEFAULT_DIV = 50
) (
    input  logic    refclk,
    input  logic    rst_n,
    input  logic    apply_req,
    input  ch_cfg_t apply_cfg,
    output logic    apply_ack,
    output logic    outclk,
    output logic    outclk_stb
);

    localparam logic [CFG_DIV_W-1:0] ONE = CFG_DIV_W'(1);

    logic [CFG_DIV_W-1:0] cnt;
    logic [CFG_DIV_W-1:0] div;
    logic                 en;
    logic                 period_end;

`ifdef CLK_DIV_FRAC_EN
    logic [CFG_FRAC_W-1:0] frac;
    logic [CFG_FRAC_W-1:0] acc;
    logic                  ext;

    // A carry on the previous boundary stretches this period by one cycle.
    assign period_end = ext ? (cnt == div) : (cnt == div - ONE);
`else
    assign period_end = (cnt == div - ONE);
`endif

    // A stopped channel has no boundary to wait for, so it takes config at once.
    assign apply_ack = apply_req & (~en | period_end);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            div        <= CFG_DIV_W'(DEFAULT_DIV);
            en         <= 1'b1;
            outclk     <= 1'b0;
            outclk_stb <= 1'b0;
`ifdef CLK_DIV_FRAC_EN
            frac       <= '0;
            acc        <= '0;
            ext        <= 1'b0;
`endif
        end else begin
            outclk     <= en & (cnt < (div >> 1));
            outclk_stb <= en & (cnt == '0);
            if (apply_ack) begin
                div <= apply_cfg.div;
                en  <= apply_cfg.en;
                cnt <= apply_cfg.en ? apply_cfg.phase : '0;
`ifdef CLK_DIV_FRAC_EN
                frac <= apply_cfg.frac;
                acc  <= '0;
                ext  <= 1'b0;
`endif
            end else if (en) begin
                if (period_end) begin
                    cnt <= '0;
`ifdef CLK_DIV_FRAC_EN
                    {ext, acc} <= {1'b0, acc} + {1'b0, frac};
`endif
                end else begin
                    cnt <= cnt + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock/strobe generator; CLK_DIV_FRAC_EN enables fractional division
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 50,
    parameter int LOCK_CYCLES = 64,
`ifdef CLK_DIV_FRAC_EN
    parameter int FRAC_W      = 8,
`endif
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic              cfg_en,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
`ifdef CLK_DIV_FRAC_EN
    input  logic [FRAC_W-1:0] cfg_frac,
`endif
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outclk_stb,
    output logic              locked
);

    localparam int              LCK_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);

    logic              pend_valid;
    logic [CH_W-1:0]   pend_ch;
    ch_cfg_t           pend_cfg;
    ch_cfg_t           new_cfg;
    logic              accept;
    logic              pend_bad;
    logic [NUM_CH-1:0] apply_req;
    logic [NUM_CH-1:0] apply_ack;
    logic [LCK_W-1:0]  lock_cnt;

    assign cfg_ready = ~pend_valid;
    assign accept    = cfg_valid & cfg_ready;
    assign locked    = (lock_cnt == LCK_W'(LOCK_CYCLES));
    // An out-of-range channel would never apply; drop it so the slot cannot wedge.
    assign pend_bad  = pend_valid && ({1'b0, pend_ch} >= NUM_CH_V);

    always_comb begin
        new_cfg       = '0;
        new_cfg.en    = cfg_en;
        new_cfg.div   = clamp_div(CFG_DIV_W'(cfg_div));
        new_cfg.phase = clamp_phase(CFG_DIV_W'(cfg_phase), new_cfg.div);
`ifdef CLK_DIV_FRAC_EN
        new_cfg.frac  = CFG_FRAC_W'(cfg_frac);
`endif
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_ch    <= '0;
            pend_cfg   <= '0;
        end else if (accept) begin
            pend_valid <= 1'b1;
            pend_ch    <= cfg_ch;
            pend_cfg   <= new_cfg;
        end else if ((|apply_ack) || pend_bad) begin
            pend_valid <= 1'b0;
        end
    end

    // Lock counts only settled cycles; any accept, even a repeat, restarts it.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
        end else if (accept) begin
            lock_cnt <= '0;
        end else if (!pend_valid && !locked) begin
            lock_cnt <= lock_cnt + LCK_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign apply_req[i] = pend_valid && (pend_ch == CH_W'(i));

        clk_div_ch #(
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .refclk     (refclk),
            .rst_n      (rst_n),
            .apply_req  (apply_req[i]),
            .apply_cfg  (pend_cfg),
            .apply_ack  (apply_ack[i]),
            .outclk     (outclk[i]),
            .outclk_stb (outclk_stb[i])
        );
    end

endmodule
